// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit -- multi-cycle RV32M divider (DIV / DIVU / REM / REMU)
//
// Radix-2 restoring division, one quotient bit per clock. Signed operations
// divide the magnitudes and fix up the result signs on the final iteration.
//
// Timing: the edge that sees start_i in IDLE ("edge 0") latches the operands
// and a pending request. The next edge moves the FSM to CALC, or straight to
// DONE for a zero divisor. CALC then runs WIDTH iterations, so done_o pulses
// after edge WIDTH+1.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   start_i      request; operands valid and held while high
//   annul_i      abort the current operation (pipeline flush)
//   signed_i     1 = DIV/REM, 0 = DIVU/REMU
//   dividend_i   op1
//   divisor_i    op2
//   quotient_o   registered quotient, held until the next DONE
//   remainder_o  registered remainder, held until the next DONE
//   done_o       one-cycle result-valid pulse (state DONE, not annulled)
//   busy_o       high while the FSM is in CALC
//
// Build option
//   DIV_EARLY_OUT_EN  when defined, a nonzero divisor whose magnitude exceeds
//                     the dividend magnitude takes the one-cycle path with
//                     q = 0 and r = dividend_i. Results are the same either
//                     way; only the latency changes.
// ----------------------------------------------------------------------------

module div_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             done_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(WIDTH - 1);

    state_e               state_q, state_d;
    logic                 req_q, req_d;          // operands latched, FSM not yet started
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;          // partial remainder
    logic [WIDTH-1:0]     quo_q, quo_d;          // |dividend| shifting out, quotient shifting in
    logic [WIDTH-1:0]     dvs_q, dvs_d;          // |divisor|
    logic [WIDTH-1:0]     raw_q, raw_d;          // untouched dividend for div-by-zero / early out
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic [WIDTH-1:0]     quotient_q, quotient_d;
    logic [WIDTH-1:0]     remainder_q, remainder_d;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // the correct unsigned magnitude 2^(WIDTH-1).
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;

    assign dvd_neg = signed_i & dividend_i[WIDTH-1];
    assign dvs_neg = signed_i & divisor_i[WIDTH-1];
    assign dvd_abs = dvd_neg ? ({WIDTH{1'b0}} - dividend_i) : dividend_i;
    assign dvs_abs = dvs_neg ? ({WIDTH{1'b0}} - divisor_i) : divisor_i;

    // One restoring step. rem_q < dvs_q always holds, so a non-negative trial
    // result fits in WIDTH bits and bit WIDTH is a clean borrow flag.
    logic [WIDTH:0]   rem_shift, trial;
    logic             step_ge;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic [WIDTH-1:0] q_fix, r_fix;

    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        step_ge   = ~trial[WIDTH];
        rem_next  = step_ge ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], step_ge};
        q_fix     = q_neg_q ? ({WIDTH{1'b0}} - quo_next) : quo_next;
        r_fix     = r_neg_q ? ({WIDTH{1'b0}} - rem_next) : rem_next;
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        raw_d       = raw_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        unique case (state_q)
            StIdle: begin
                if (annul_i) begin
                    // A flush also drops a request latched but not yet started.
                    req_d = 1'b0;
                end else if (!req_q) begin
                    if (start_i) begin
                        req_d   = 1'b1;
                        rem_d   = '0;
                        quo_d   = dvd_abs;
                        dvs_d   = dvs_abs;
                        raw_d   = dividend_i;
                        q_neg_d = dvd_neg ^ dvs_neg;
                        r_neg_d = dvd_neg;
                    end
                end else begin
                    req_d = 1'b0;
                    if (dvs_q == '0) begin
                        state_d     = StDone;
                        quotient_d  = '1;
                        remainder_d = raw_q;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (quo_q < dvs_q) begin
                        state_d     = StDone;
                        quotient_d  = '0;
                        remainder_d = raw_q;
                    end
`endif
                    else begin
                        state_d = StCalc;
                        cnt_d   = '0;
                    end
                end
            end

            StCalc: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == LastCnt) begin
                        state_d     = StDone;
                        quotient_d  = q_fix;
                        remainder_d = r_fix;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            raw_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            raw_q       <= raw_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    // A flush in the DONE cycle suppresses the result pulse.
    assign done_o      = (state_q == StDone) && !annul_i;
    assign busy_o      = (state_q == StCalc);

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit -- directed-vector bench for div_unit (WIDTH = 32).
// Edge 0 is the first rising edge that sees start_i high; outputs are sampled
// 1 ns after each rising edge.
// ----------------------------------------------------------------------------

module tb_div_unit;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        done_o;
    logic        busy_o;

    int n_cmp;
    int n_bad;

    div_unit #(
        .WIDTH     (32),
        .CNT_WIDTH (6)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .done_o      (done_o),
        .busy_o      (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one operation and watch 40 edges. Start is dropped once done_o
    // is seen. Checks latency, result, busy cycle count, single done pulse and
    // that the result holds after returning to IDLE.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input int exp_lat,
                          input int exp_busy);
        int          lat;
        int          busy_n;
        int          done_n;
        logic [31:0] q_s;
        logic [31:0] r_s;
        lat    = -1;
        busy_n = 0;
        done_n = 0;
        q_s    = '0;
        r_s    = '0;
        @(negedge clk_i);
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk_i);
            #1;
            if (busy_o) busy_n++;
            if (done_o) begin
                done_n++;
                if (lat < 0) begin
                    lat = e;
                    q_s = quotient_o;
                    r_s = remainder_o;
                end
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " quotient"}, q_s, exp_q);
        check({tag, " remainder"}, r_s, exp_r);
        check({tag, " busy cycles"}, busy_n, exp_busy);
        check({tag, " done pulses"}, done_n, 1);
        check({tag, " quotient held"}, quotient_o, exp_q);
    endtask

    initial begin
        int done_n;
        n_cmp      = 0;
        n_bad      = 0;
        rst_i      = 1'b0;
        start_i    = 1'b0;
        annul_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;

        #2;
        check("reset quotient", quotient_o, 32'h0);
        check("reset remainder", remainder_o, 32'h0);
        check("reset done", done_o, 0);
        check("reset busy", busy_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        run_op("u 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 32);
        run_op("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 32);
        run_op("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 32);
        run_op("s -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 33, 32);
        run_op("u 0x1234/0", 1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1, 0);
        run_op("s 0x1234/0", 1'b1, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1, 0);
        run_op("s -7/0", 1'b1, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1, 0);
        run_op("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33, 32);
        run_op("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0, 33, 32);
        run_op("u max/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33, 32);
`ifdef DIV_EARLY_OUT_EN
        run_op("u 3/10", 1'b0, 32'd3, 32'd10, 32'h0, 32'd3, 1, 0);
        run_op("s -3/10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'h0, 32'hFFFF_FFFD, 1, 0);
`else
        run_op("u 3/10", 1'b0, 32'd3, 32'd10, 32'h0, 32'd3, 33, 32);
        run_op("s -3/10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'h0, 32'hFFFF_FFFD, 33, 32);
`endif

        // Annul in CALC: 20/3 aborted in cycle 10, idle at edge 11, no pulse,
        // previous result (-3/10) untouched.
        done_n = 0;
        @(negedge clk_i);
        signed_i   = 1'b0;
        dividend_i = 32'd20;
        divisor_i  = 32'd3;
        start_i    = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            @(posedge clk_i);
            #1;
            if (done_o) done_n++;
        end
        check("annul busy before", busy_o, 1);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("annul busy after", busy_o, 0);
        annul_i = 1'b0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o) done_n++;
        end
        check("annul no done", done_n, 0);
        check("annul q kept", quotient_o, 32'h0);
        check("annul r kept", remainder_o, 32'hFFFF_FFFD);

        run_op("u 20/3 restart", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 33, 32);

        // Annul in IDLE: a start seen together with annul is ignored.
        done_n = 0;
        @(negedge clk_i);
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        start_i    = 1'b1;
        annul_i    = 1'b1;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o) done_n++;
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o) done_n++;
        end
        check("idle annul ignored", done_n, 0);

        // Annul in DONE: the pulse is suppressed and the FSM still returns idle.
        @(negedge clk_i);
        dividend_i = 32'h55;
        divisor_i  = 32'h0;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        #1;
        check("done annul pulse", done_o, 0);
        @(posedge clk_i);
        #1;
        annul_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("done annul idle", done_o | busy_o, 0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk_i);
        signed_i   = 1'b0;
        dividend_i = 32'd20;
        divisor_i  = 32'd3;
        start_i    = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            @(posedge clk_i);
            #1;
        end
        check("pre-reset busy", busy_o, 1);
        rst_i = 1'b0;
        #1;
        check("async rst quotient", quotient_o, 32'h0);
        check("async rst remainder", remainder_o, 32'h0);
        check("async rst busy", busy_o, 0);
        check("async rst done", done_o, 0);
        @(negedge clk_i);
        start_i = 1'b0;
        rst_i   = 1'b1;

        run_op("u 20/3 after rst", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 33, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
